// File: rtl/rns_pkg.sv
// Shared definitions for the RNS constant comparator: default moduli (7, 8, 9),
// residue widths, MRC inverses, default compare constant and FSM state encoding.
package rns_pkg;

    localparam int DEF_M1     = 7;
    localparam int DEF_M2     = 8;
    localparam int DEF_M3     = 9;
    localparam int DEF_W1     = 3;
    localparam int DEF_W2     = 3;
    localparam int DEF_W3     = 4;
    localparam int DEF_INV12  = 7;   // M1^-1 mod M2
    localparam int DEF_INV13  = 4;   // M1^-1 mod M3
    localparam int DEF_INV23  = 8;   // M2^-1 mod M3
    localparam int DEF_M      = DEF_M1 * DEF_M2 * DEF_M3;
    localparam int DEF_C_INIT = 10;

    // Residues of the default constant
    localparam int DEF_C1 = DEF_C_INIT % DEF_M1;
    localparam int DEF_C2 = DEF_C_INIT % DEF_M2;
    localparam int DEF_C3 = DEF_C_INIT % DEF_M3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_DONE = 2'd3
    } rns_state_e;

endpackage

// File: rtl/rns_mrc3_step.sv
// One lane of the 3-channel mixed-radix conversion, purely combinational.
// Stage 1 (r1,r2,r3 -> a1,a2,t3) and stage 2 (t3,a2 -> a3) are exposed
// separately so the caller decides where the pipeline register sits.
module rns_mrc3_step #(
    parameter int M1    = 7,
    parameter int M2    = 8,
    parameter int M3    = 9,
    parameter int W1    = 3,
    parameter int W2    = 3,
    parameter int W3    = 4,
    parameter int INV12 = 7,
    parameter int INV13 = 4,
    parameter int INV23 = 8
) (
    input  logic [W1-1:0] r1_i,
    input  logic [W2-1:0] r2_i,
    input  logic [W3-1:0] r3_i,
    output logic [W1-1:0] a1_o,
    output logic [W2-1:0] a2_o,
    output logic [W3-1:0] t3_o,
    input  logic [W2-1:0] a2_i,
    input  logic [W3-1:0] t3_i,
    output logic [W3-1:0] a3_o
);

    localparam logic [W2:0]     M2_S    = (W2+1)'(M2);
    localparam logic [W3:0]     M3_S    = (W3+1)'(M3);
    localparam logic [2*W2:0]   M2_P    = (2*W2+1)'(M2);
    localparam logic [2*W3:0]   M3_P    = (2*W3+1)'(M3);
    localparam logic [2*W2:0]   INV12_P = (2*W2+1)'(INV12);
    localparam logic [2*W3:0]   INV13_P = (2*W3+1)'(INV13);
    localparam logic [2*W3:0]   INV23_P = (2*W3+1)'(INV23);

    logic [W2:0]   s2, d2;
    logic [W3:0]   s3, d3, s3b, d3b;
    logic [2*W2:0] p2;
    logic [2*W3:0] p3, p3b;

    // Stage 1: a1 = r1, a2 = (r2-a1)*INV12 mod M2, t3 = (r3-a1)*INV13 mod M3
    always_comb begin
        a1_o = r1_i;
        s2   = {1'b0, r2_i} + M2_S - (W2+1)'(r1_i);
        d2   = (s2 >= M2_S) ? (s2 - M2_S) : s2;
        p2   = (2*W2+1)'(d2) * INV12_P;
        a2_o = W2'(p2 % M2_P);
        s3   = {1'b0, r3_i} + M3_S - (W3+1)'(r1_i);
        d3   = (s3 >= M3_S) ? (s3 - M3_S) : s3;
        p3   = (2*W3+1)'(d3) * INV13_P;
        t3_o = W3'(p3 % M3_P);
    end

    // Stage 2: a3 = (t3-a2)*INV23 mod M3
    always_comb begin
        s3b  = {1'b0, t3_i} + M3_S - (W3+1)'(a2_i);
        d3b  = (s3b >= M3_S) ? (s3b - M3_S) : s3b;
        p3b  = (2*W3+1)'(d3b) * INV23_P;
        a3_o = W3'(p3b % M3_P);
    end

endmodule

// File: rtl/rns_compare_seq.sv
// Sequential magnitude comparator of a 3-channel RNS operand X against a
// constant C. Both are converted to mixed-radix digits (a3,a2,a1) over two
// cycles and compared most significant digit first.
// Optional feature macro: RNS_CMP_CONST_LOAD_EN adds const_we/c1..c3 so the
// constant can be reloaded at run time; otherwise C is fixed to C_INIT.
module rns_compare_seq
    import rns_pkg::*;
#(
    parameter int M1     = DEF_M1,
    parameter int M2     = DEF_M2,
    parameter int M3     = DEF_M3,
    parameter int W1     = DEF_W1,
    parameter int W2     = DEF_W2,
    parameter int W3     = DEF_W3,
    parameter int INV12  = DEF_INV12,
    parameter int INV13  = DEF_INV13,
    parameter int INV23  = DEF_INV23,
    parameter int C_INIT = DEF_C_INIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W1-1:0] x1,
    input  logic [W2-1:0] x2,
    input  logic [W3-1:0] x3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          le,
    output logic          eq,
    output logic          gr,
    output logic          err
`ifdef RNS_CMP_CONST_LOAD_EN
    ,
    input  logic          const_we,
    input  logic [W1-1:0] c1,
    input  logic [W2-1:0] c2,
    input  logic [W3-1:0] c3
`endif
);

    localparam logic [W1:0]   M1_C    = (W1+1)'(M1);
    localparam logic [W2:0]   M2_C    = (W2+1)'(M2);
    localparam logic [W3:0]   M3_C    = (W3+1)'(M3);
    localparam logic [W1-1:0] C1_INIT = W1'(C_INIT % M1);
    localparam logic [W2-1:0] C2_INIT = W2'(C_INIT % M2);
    localparam logic [W3-1:0] C3_INIT = W3'(C_INIT % M3);
    localparam int            KW      = W1 + W2 + W3;

    rns_state_e state_q, state_d;

    logic [W1-1:0] xr1_q;
    logic [W2-1:0] xr2_q;
    logic [W3-1:0] xr3_q;
    logic [W1-1:0] xa1_q;
    logic [W2-1:0] xa2_q;
    logic [W3-1:0] xt3_q;
    logic          in_err_q;
    logic          le_q, eq_q, gr_q, err_q;

    logic [W1-1:0] xl_a1, cl_a1, c_r1, c_a1_dig;
    logic [W2-1:0] xl_a2, cl_a2, c_r2, c_a2_dig, c_a2_in;
    logic [W3-1:0] xl_t3, cl_t3, c_r3, c_t3_in;
    logic [W3-1:0] xl_a3, cl_a3;
    logic          x_err, c_err, accept;
    logic [KW-1:0] x_key, c_key;

    assign accept    = (state_q == ST_IDLE) && in_valid;
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign le        = le_q;
    assign eq        = eq_q;
    assign gr        = gr_q;
    assign err       = err_q;

    assign x_err = ({1'b0, x1} >= M1_C) | ({1'b0, x2} >= M2_C) | ({1'b0, x3} >= M3_C);

`ifdef RNS_CMP_CONST_LOAD_EN
    logic [W1-1:0] cc1_q, cs1_q, ca1_q;
    logic [W2-1:0] cc2_q, cs2_q, ca2_q;
    logic [W3-1:0] cc3_q, cs3_q, ct3_q;

    // An out-of-range loaded constant poisons every op that snapshots it
    assign c_err    = ({1'b0, cc1_q} >= M1_C) | ({1'b0, cc2_q} >= M2_C) | ({1'b0, cc3_q} >= M3_C);
    assign c_r1     = cs1_q;
    assign c_r2     = cs2_q;
    assign c_r3     = cs3_q;
    assign c_a2_in  = ca2_q;
    assign c_t3_in  = ct3_q;
    assign c_a1_dig = ca1_q;
    assign c_a2_dig = ca2_q;

    // Run-time constant register, writable in any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc1_q <= C1_INIT;
            cc2_q <= C2_INIT;
            cc3_q <= C3_INIT;
        end else if (const_we) begin
            cc1_q <= c1;
            cc2_q <= c2;
            cc3_q <= c3;
        end
    end

    // Per-op snapshot of C and the C lane's stage-1 pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs1_q <= '0;
            cs2_q <= '0;
            cs3_q <= '0;
            ca1_q <= '0;
            ca2_q <= '0;
            ct3_q <= '0;
        end else begin
            if (accept) begin
                cs1_q <= cc1_q;
                cs2_q <= cc2_q;
                cs3_q <= cc3_q;
            end
            if (state_q == ST_S1) begin
                ca1_q <= cl_a1;
                ca2_q <= cl_a2;
                ct3_q <= cl_t3;
            end
        end
    end
`else
    // Fixed constant: the C lane folds to elaboration-time digits
    assign c_err    = 1'b0;
    assign c_r1     = C1_INIT;
    assign c_r2     = C2_INIT;
    assign c_r3     = C3_INIT;
    assign c_a2_in  = cl_a2;
    assign c_t3_in  = cl_t3;
    assign c_a1_dig = cl_a1;
    assign c_a2_dig = cl_a2;
`endif

    rns_mrc3_step #(
        .M1(M1), .M2(M2), .M3(M3), .W1(W1), .W2(W2), .W3(W3),
        .INV12(INV12), .INV13(INV13), .INV23(INV23)
    ) u_x_lane (
        .r1_i(xr1_q), .r2_i(xr2_q), .r3_i(xr3_q),
        .a1_o(xl_a1), .a2_o(xl_a2), .t3_o(xl_t3),
        .a2_i(xa2_q), .t3_i(xt3_q), .a3_o(xl_a3)
    );

    rns_mrc3_step #(
        .M1(M1), .M2(M2), .M3(M3), .W1(W1), .W2(W2), .W3(W3),
        .INV12(INV12), .INV13(INV13), .INV23(INV23)
    ) u_c_lane (
        .r1_i(c_r1), .r2_i(c_r2), .r3_i(c_r3),
        .a1_o(cl_a1), .a2_o(cl_a2), .t3_o(cl_t3),
        .a2_i(c_a2_in), .t3_i(c_t3_in), .a3_o(cl_a3)
    );

    // Digit keys: concatenating (a3,a2,a1) makes an unsigned compare lexicographic
    assign x_key = {xl_a3, xa2_q, xa1_q};
    assign c_key = {cl_a3, c_a2_dig, c_a1_dig};

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture and X lane stage-1 pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr1_q    <= '0;
            xr2_q    <= '0;
            xr3_q    <= '0;
            in_err_q <= 1'b0;
            xa1_q    <= '0;
            xa2_q    <= '0;
            xt3_q    <= '0;
        end else begin
            if (accept) begin
                xr1_q    <= x1;
                xr2_q    <= x2;
                xr3_q    <= x3;
                in_err_q <= x_err | c_err;
            end
            if (state_q == ST_S1) begin
                xa1_q <= xl_a1;
                xa2_q <= xl_a2;
                xt3_q <= xl_t3;
            end
        end
    end

    // Result flags, registered at the end of S2 and held through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            le_q  <= 1'b0;
            eq_q  <= 1'b0;
            gr_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (state_q == ST_S2) begin
            le_q  <= !in_err_q && (x_key <  c_key);
            eq_q  <= !in_err_q && (x_key == c_key);
            gr_q  <= !in_err_q && (x_key >  c_key);
            err_q <= in_err_q;
        end
    end

endmodule
